// File: rtl/axi4_lite_reg_bank_if.sv
// AXI4-Lite bus bundle shared by the register bank and its masters.
interface ifc_axi4_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite slave register bank with per-register write pulses.
// Define AXI4_LITE_REG_BANK_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi4_lite_reg_bank_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  output logic [DATA_WIDTH-1:0]   o_q,
  output logic                    o_pulse
);
  logic [DATA_WIDTH-1:0] r_q;
  logic                  r_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= i_we;
      if (i_we) begin
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
          if (i_wstrb[b]) r_q[b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_q     = r_q;
  assign o_pulse = r_pulse;
endmodule

module axi4_lite_reg_bank #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,   // 32 or 64
  parameter int NUM_REGS   = 8     // power of two, >= 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  ifc_axi4_lite.slave                    s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int STRB_W = DATA_WIDTH/8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4_LITE_REG_BANK_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_regs;
  logic [NUM_REGS-1:0]                 w_pulse;
  logic [NUM_REGS-1:0]                 w_we;

  // ---------------- write path ----------------
  logic                  r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;

  logic                  w_aw_hs, w_w_hs, w_commit, w_wr_in_range;
  logic [ADDR_WIDTH-1:0] w_aw_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_W-1:0]     w_wstrb;
  logic [IDX_W-1:0]      w_wr_idx;

  assign s_axi.awready = !r_aw_held && !r_bvalid;
  assign s_axi.wready  = !r_w_held  && !r_bvalid;
  assign w_aw_hs       = s_axi.awvalid && s_axi.awready;
  assign w_w_hs        = s_axi.wvalid  && s_axi.wready;

  // A held beat wins over the bus; the bus value is used only while handshaking.
  assign w_aw_addr     = r_aw_held ? r_awaddr : s_axi.awaddr;
  assign w_wdata       = r_w_held  ? r_wdata  : s_axi.wdata;
  assign w_wstrb       = r_w_held  ? r_wstrb  : s_axi.wstrb;
  assign w_commit      = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_wr_idx      = w_aw_addr[LSB +: IDX_W];
  assign w_wr_in_range = (w_aw_addr >> (LSB + IDX_W)) == '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_aw_hs) r_awaddr <= s_axi.awaddr;
      if (w_w_hs) begin
        r_wdata <= s_axi.wdata;
        r_wstrb <= s_axi.wstrb;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_in_range ? RESP_OKAY : RESP_OOR;
      end else begin
        if (w_aw_hs) r_aw_held <= 1'b1;
        if (w_w_hs)  r_w_held  <= 1'b1;
        if (r_bvalid && s_axi.bready) r_bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_we = '0;
    if (w_commit && w_wr_in_range) w_we[w_wr_idx] = 1'b1;
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    axi4_lite_reg_bank_reg #(.DATA_WIDTH(DATA_WIDTH)) u_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_we[gi]),
      .i_wdata (w_wdata),
      .i_wstrb (w_wstrb),
      .o_q     (w_regs[gi]),
      .o_pulse (w_pulse[gi])
    );
  end

  assign s_axi.bvalid = r_bvalid;
  assign s_axi.bresp  = r_bresp;
  assign reg_out      = w_regs;
  assign wr_pulse     = w_pulse;

  // ---------------- read path ----------------
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  w_ar_hs, w_rd_in_range;
  logic [IDX_W-1:0]      w_rd_idx;

  assign s_axi.arready = !r_rvalid;
  assign w_ar_hs       = s_axi.arvalid && !r_rvalid;
  assign w_rd_idx      = s_axi.araddr[LSB +: IDX_W];
  assign w_rd_in_range = (s_axi.araddr >> (LSB + IDX_W)) == '0;

  // Sampling the register flops gives the pre-write value on a colliding commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_in_range ? w_regs[w_rd_idx] : '0;
      r_rresp  <= w_rd_in_range ? RESP_OKAY : RESP_OOR;
    end else if (r_rvalid && s_axi.rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign s_axi.rvalid = r_rvalid;
  assign s_axi.rdata  = r_rdata;
  assign s_axi.rresp  = r_rresp;

  logic w_unused;
  assign w_unused = ^{s_axi.awprot, s_axi.arprot, w_aw_addr[LSB-1:0], s_axi.araddr[LSB-1:0]};
endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// Bench for axi4_lite_reg_bank: directed bus scenarios, then randomized traffic against an array model.
module tb_axi4_lite_reg_bank;
  localparam int AW = 32, DW = 32, NR = 8;
`ifdef AXI4_LITE_REG_BANK_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]    wr_pulse;

  ifc_axi4_lite #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi4_lite_reg_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_axi    (axi),
    .reg_out  (reg_out),
    .wr_pulse (wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] model [NR];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return a < NR*4;
  endfunction

  function automatic logic [NR*DW-1:0] packed_model();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
    return v;
  endfunction

  function automatic logic [NR-1:0] exp_pulse(input logic [31:0] a);
    logic [NR-1:0] p;
    p = '0;
    if (in_rng(a)) p[a[4:2]] = 1'b1;
    return p;
  endfunction

  task automatic apply_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_rng(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a[4:2]][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // mode 0: AW+W together; 1: AW then W after gap; 2: W then AW after gap
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int mode, input int gap, input int bdly);
    chk("awready_idle", axi.awready, 1'b1);
    chk("wready_idle", axi.wready, 1'b1);
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s; axi.bready = 1'b0;
    if (mode == 0) begin
      axi.awvalid = 1'b1; axi.wvalid = 1'b1;
      tick();
    end else if (mode == 1) begin
      axi.awvalid = 1'b1;
      tick();
      axi.awvalid = 1'b0;
      for (int i = 0; i < gap; i++) begin
        chk("aw_only_no_b", axi.bvalid, 1'b0);
        chk("aw_held_awready", axi.awready, 1'b0);
        tick();
      end
      axi.wvalid = 1'b1;
      tick();
    end else begin
      axi.wvalid = 1'b1;
      tick();
      axi.wvalid = 1'b0;
      for (int i = 0; i < gap; i++) begin
        chk("w_only_no_b", axi.bvalid, 1'b0);
        chk("w_held_wready", axi.wready, 1'b0);
        tick();
      end
      axi.awvalid = 1'b1;
      tick();
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    apply_write(a, d, s);
    chk("commit_bvalid", axi.bvalid, 1'b1);
    chk("commit_bresp", axi.bresp, in_rng(a) ? 2'b00 : ERR);
    chk("commit_regs", reg_out, packed_model());
    chk("commit_pulse", wr_pulse, exp_pulse(a));
    for (int i = 0; i < bdly; i++) begin
      tick();
      chk("b_hold_valid", axi.bvalid, 1'b1);
      chk("b_hold_resp", axi.bresp, in_rng(a) ? 2'b00 : ERR);
      chk("b_hold_pulse", wr_pulse, '0);
      chk("b_hold_awready", axi.awready, 1'b0);
    end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    chk("b_done", axi.bvalid, 1'b0);
    chk("b_done_pulse", wr_pulse, '0);
  endtask

  task automatic rd(input logic [31:0] a, input int rdly);
    logic [31:0] ev;
    ev = in_rng(a) ? model[a[4:2]] : 32'h0;
    chk("arready_idle", axi.arready, 1'b1);
    axi.araddr = a; axi.arvalid = 1'b1; axi.rready = 1'b0;
    tick();
    axi.arvalid = 1'b0;
    chk("r_valid", axi.rvalid, 1'b1);
    chk("r_data", axi.rdata, ev);
    chk("r_resp", axi.rresp, in_rng(a) ? 2'b00 : ERR);
    chk("r_arready_low", axi.arready, 1'b0);
    for (int i = 0; i < rdly; i++) begin
      tick();
      chk("r_hold_valid", axi.rvalid, 1'b1);
      chk("r_hold_data", axi.rdata, ev);
      chk("r_hold_arready", axi.arready, 1'b0);
    end
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
    chk("r_done", axi.rvalid, 1'b0);
    chk("r_done_arready", axi.arready, 1'b1);
  endtask

  // write and read issued on the same edge; the read must see the pre-write value
  task automatic conc(input logic [31:0] wa, input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] ra);
    logic [31:0] ev;
    ev = in_rng(ra) ? model[ra[4:2]] : 32'h0;
    axi.awaddr = wa; axi.wdata = d; axi.wstrb = s; axi.araddr = ra;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
    axi.bready = 1'b0; axi.rready = 1'b0;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    apply_write(wa, d, s);
    chk("conc_rdata_old", axi.rdata, ev);
    chk("conc_regs", reg_out, packed_model());
    chk("conc_bvalid", axi.bvalid, 1'b1);
    chk("conc_rvalid", axi.rvalid, 1'b1);
    axi.bready = 1'b1; axi.rready = 1'b1;
    tick();
    axi.bready = 1'b0; axi.rready = 1'b0;
    chk("conc_b_done", axi.bvalid, 1'b0);
    chk("conc_r_done", axi.rvalid, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) < 8) return ($urandom_range(0, NR-1) << 2) | $urandom_range(0, 3);
    return $urandom() | 32'h20;
  endfunction

  initial begin
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;

    #1;
    chk("rst_regs", reg_out, '0);
    chk("rst_pulse", wr_pulse, '0);
    chk("rst_bvalid", axi.bvalid, 1'b0);
    chk("rst_rvalid", axi.rvalid, 1'b0);
    chk("rst_rdata", axi.rdata, '0);
    chk("rst_bresp", axi.bresp, '0);
    chk("rst_rresp", axi.rresp, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rel_awready", axi.awready, 1'b1);
    chk("rel_wready", axi.wready, 1'b1);
    chk("rel_arready", axi.arready, 1'b1);
    tick();

    // simultaneous AW+W to reg1
    wr(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    chk("dir_reg1", reg_out[1*DW +: DW], 32'hDEADBEEF);

    // W three cycles ahead of AW, partial strobe
    wr(32'h08, 32'hAAAAAAAA, 4'hF, 0, 0, 0);
    wr(32'h08, 32'h11223344, 4'h5, 2, 2, 0);
    chk("dir_reg2_merge", reg_out[2*DW +: DW], 32'hAA22AA44);

    // B backpressure for 5 cycles with a second write stalled behind it
    axi.awaddr = 32'h0C; axi.wdata = 32'h5A; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
    tick();
    apply_write(32'h0C, 32'h5A, 4'hF);
    axi.awaddr = 32'h10; axi.wdata = 32'h77;
    chk("bp_bvalid0", axi.bvalid, 1'b1);
    chk("bp_reg3", reg_out[3*DW +: DW], 32'h5A);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_bvalid", axi.bvalid, 1'b1);
      chk("bp_awready", axi.awready, 1'b0);
      chk("bp_wready", axi.wready, 1'b0);
      chk("bp_reg4_untouched", reg_out[4*DW +: DW], 32'h0);
    end
    axi.bready = 1'b1;
    tick();
    chk("bp_released", axi.bvalid, 1'b0);
    chk("bp_awready_back", axi.awready, 1'b1);
    chk("bp_wready_back", axi.wready, 1'b1);
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    apply_write(32'h10, 32'h77, 4'hF);
    chk("bp_second_bvalid", axi.bvalid, 1'b1);
    chk("bp_second_reg4", reg_out[4*DW +: DW], 32'h77);
    chk("bp_second_pulse", wr_pulse, 8'h10);
    tick();
    axi.bready = 1'b0;
    chk("bp_second_done", axi.bvalid, 1'b0);

    // read reg3 with R backpressure
    rd(32'h0C, 2);

    // out-of-range write and read
    wr(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    rd(32'h40, 0);

    // reset mid-transaction
    axi.awaddr = 32'h0; axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    chk("mid_aw_held", axi.awready, 1'b0);
    axi.araddr = 32'h0C; axi.arvalid = 1'b1; axi.rready = 1'b0;
    tick();
    axi.arvalid = 1'b0;
    chk("mid_rvalid", axi.rvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    chk("mid_rst_regs", reg_out, '0);
    chk("mid_rst_pulse", wr_pulse, '0);
    chk("mid_rst_bvalid", axi.bvalid, 1'b0);
    chk("mid_rst_rvalid", axi.rvalid, 1'b0);
    chk("mid_rst_rdata", axi.rdata, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid_rel_awready", axi.awready, 1'b1);
    chk("mid_rel_arready", axi.arready, 1'b1);
    axi.wdata = 32'h1234; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    tick();
    axi.wvalid = 1'b0;
    chk("mid_w_alone_bvalid", axi.bvalid, 1'b0);
    chk("mid_w_alone_regs", reg_out, '0);
    chk("mid_w_alone_pulse", wr_pulse, '0);
    tick();
    chk("mid_w_alone_bvalid2", axi.bvalid, 1'b0);
    axi.awaddr = 32'h14; axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    apply_write(32'h14, 32'h1234, 4'hF);
    chk("mid_complete_bvalid", axi.bvalid, 1'b1);
    chk("mid_complete_regs", reg_out, packed_model());
    chk("mid_complete_pulse", wr_pulse, 8'h20);
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;

    // read/write collision on the same register
    conc(32'h14, 32'hCAFEF00D, 4'hF, 32'h14);
    chk("conc_reg5", reg_out[5*DW +: DW], 32'hCAFEF00D);

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 2))
        0: wr(rand_addr(), $urandom(), 4'($urandom_range(0, 15)),
              $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
        1: rd(rand_addr(), $urandom_range(0, 2));
        default: conc(rand_addr(), $urandom(), 4'($urandom_range(0, 15)), rand_addr());
      endcase
    end
    chk("final_regs", reg_out, packed_model());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4_lite_reg_bank.md
AXI4_LITE_REG_BANK -- requirements
Module: axi4_lite_reg_bank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register/bus width; only 32 or 64 legal.
REQ-003 SHALL have parameter NUM_REGS, default 8, register count; power of two, >= 2.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port s_axi, ifc_axi4_lite.slave modport, ADDR_WIDTH/DATA_WIDTH, AXI4-Lite slave bus.
REQ-007 SHALL have port reg_out, output, NUM_REGS*DATA_WIDTH, register i on bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port wr_pulse, output, NUM_REGS, bit i high one cycle per committed write to register i.

Function
REQ-009 SHALL decode index = addr[LSB +: log2(NUM_REGS)], LSB = log2(DATA_WIDTH/8); addr bits below LSB ignored.
REQ-010 SHALL treat an address >= NUM_REGS*DATA_WIDTH/8 as out of range; awprot/arprot ignored.
REQ-011 SHALL have write flags aw_held and w_held; awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
REQ-012 SHALL capture awaddr on an AW handshake, wdata/wstrb on a W handshake, and set the matching flag; AW and W may arrive in either order or in the same cycle.
REQ-013 SHALL commit on the edge where address and data are both available (held or handshaking): update bytes with wstrb=1, keep bytes with wstrb=0, set bvalid=1, bresp=OKAY, clear both flags.
REQ-014 SHALL give commit latency as: simultaneous AW+W handshake at edge k -> reg_out updated, wr_pulse bit high, and bvalid=1 in the cycle after edge k.
REQ-015 SHALL hold bvalid/bresp stable until bready; bvalid clears on the B handshake edge; awready/wready rise the cycle after.
REQ-016 SHALL never write an out-of-range address and never pulse wr_pulse for it.
REQ-017 SHALL drive arready = !rvalid; on an AR handshake, load rdata/rresp and set rvalid=1 at that edge.
REQ-018 SHALL hold rvalid/rdata/rresp stable until rready; rvalid clears on the R handshake edge, so sustained reads run at most one per two cycles.
REQ-019 SHALL return the pre-write value when a read samples a register on the same edge that commits a write to it.
REQ-020 SHALL run read and write paths independently and concurrently.

Reset
REQ-021 SHALL, with rst_n low, immediately force all registers, reg_out, wr_pulse, bvalid, rvalid, rdata, bresp, rresp, aw_held, w_held to 0.
REQ-022 SHALL discard partially received writes and undelivered responses on reset mid-transaction; awready/wready/arready are 1 in the first cycle after release.

Configuration
REQ-023 SHALL use macro AXI4_LITE_REG_BANK_SLVERR_EN.
REQ-024 SHALL, when the macro is defined, answer out-of-range writes and reads with resp=2'b10 (SLVERR) and rdata=0.
REQ-025 SHALL, when the macro is undefined, answer out-of-range accesses with resp=2'b00 (OKAY) and rdata=0; write still discarded.

Verification
REQ-026 SHALL cover: AW(0x04)+W(0xDEADBEEF, strb 0xF) same cycle, bready=1 -> reg1=0xDEADBEEF and wr_pulse=0x02 the next cycle, bvalid one cycle, bresp=0.
REQ-027 SHALL cover: W(0x11223344) three cycles before AW(0x08), strb 0x5 on reg2=0xAAAAAAAA -> reg2=0xAA22AA44 after AW edge; wready stays low between.
REQ-028 SHALL cover: write reg3=0x5A, bready low 5 cycles -> bvalid held 5 cycles, awready/wready low throughout, second AW stalls.
REQ-029 SHALL cover: AR(0x0C) with rready low 3 cycles -> rdata=0x5A held stable, arready low until one cycle after the R handshake.
REQ-030 SHALL cover: write and read to 0x40 (NUM_REGS=8) -> bresp/rresp=2'b10 with macro, 2'b00 without; rdata=0; no register change.
REQ-031 SHALL cover: rst_n low while aw_held=1 and rvalid=1 -> all outputs 0 immediately; later W alone does not commit.
